uart_serial: RTL and testbench

UART_SERIAL -- requirements
Module: uart_serial

---
 rtl/uart_serial_pkg.sv | 17 +
 rtl/uart_rx.sv | 116 +++++++++++
 rtl/uart_serial.sv | 110 +++++++++++
 tb/tb_uart_serial.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_serial_pkg.sv
// Shared definitions for the UART: FSM state encoding and default bit period.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_serial_pkg;

   // Both TX and RX FSMs walk the same four frame phases.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // 12 MHz raw clock / 115200 baud.
   localparam int unsigned DEFAULT_DIVISOR = 104;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes rx, mid-bit samples each bit, posts bytes with sticky flags.
// Latency: byte visible the edge after the stop-bit mid-point sample (~9.5 bits + 3 sync cycles).
// Backpressure: none on the line; an unacknowledged byte is kept and later bytes set rx_overrun.
module uart_rx
   import uart_serial_pkg::*;
#(
   parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
   input  logic       raw_clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       rx_overrun,
   output logic       rx_frame_error
);

   localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
   localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

   uart_state_t state_q;
   logic [15:0] timer_q;
   logic [15:0] timer_d;
   logic [2:0]  idx_q;
   logic [7:0]  shreg_q;
   logic [7:0]  data_q;
   logic        ready_q, overrun_q, ferr_q;
   logic        sync1_q, sync2_q, prev_q;

   assign timer_d = timer_q + 16'd1;

   // Synchronize rx, track its previous value for edge detect, and run the receive FSM.
   // The edge detector needs a high level before a low one, so after a framing
   // error on a stuck-low line the FSM only re-arms once rx has returned high.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;

         // Acknowledge clears every sticky flag; a completion below on the same
         // edge overrides this because its assignments come later.
         if (rx_ack) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (prev_q && !sync2_q) begin
                  state_q <= ST_START;
                  timer_q <= '0;
               end
            end
            ST_START: begin
               if (timer_q == HALF_LAST) begin
                  timer_q <= '0;
                  idx_q   <= '0;
                  // A high level at the start mid-point means a glitch, not a frame.
                  state_q <= sync2_q ? ST_IDLE : ST_DATA;
               end else begin
                  timer_q <= timer_d;
               end
            end
            ST_DATA: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  shreg_q <= {sync2_q, shreg_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= ST_STOP;
               end else begin
                  timer_q <= timer_d;
               end
            end
            ST_STOP: begin
               if (timer_q == BIT_LAST) begin
                  // Leave half a bit early so the next start edge is never missed.
                  timer_q <= '0;
                  state_q <= ST_IDLE;
                  if (!sync2_q) begin
                     ferr_q <= 1'b1;
                  end else if (ready_q && !rx_ack) begin
                     overrun_q <= 1'b1;
                  end else begin
                     data_q    <= shreg_q;
                     ready_q   <= 1'b1;
                     overrun_q <= 1'b0;
                  end
               end else begin
                  timer_q <= timer_d;
               end
            end
         endcase
      end
   end

   assign rx_data        = data_q;
   assign rx_ready       = ready_q;
   assign rx_overrun     = overrun_q;
   assign rx_frame_error = ferr_q;

endmodule

// File: rtl/uart_serial.sv
// Full-duplex 8N1 UART: transmit FSM here, receive path in uart_rx.
// Latency: tx goes low on the edge that accepts tx_start; frame occupies 10*DIVISOR cycles.
// Backpressure: tx_busy holds off new requests; tx_start is a level held until tx_busy is seen.
module uart_serial
   import uart_serial_pkg::*;
#(
   parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
   input  logic       raw_clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       rx_frame_error
);

   localparam logic [15:0] BIT_LAST = 16'(DIVISOR - 1);

   uart_state_t state_q;
   logic [15:0] timer_q;
   logic [15:0] timer_d;
   logic [2:0]  idx_q;
   logic [7:0]  shreg_q;
   logic        tx_q;
   logic        busy_q;

   assign timer_d = timer_q + 16'd1;

   // Transmit FSM; the byte is captured into a private shift register at frame
   // start so later tx_data changes cannot disturb the frame in flight.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tx_start) begin
                  shreg_q <= tx_data;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  timer_q <= '0;
                  idx_q   <= '0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  tx_q    <= shreg_q[0];
                  state_q <= ST_DATA;
               end else begin
                  timer_q <= timer_d;
               end
            end
            ST_DATA: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  shreg_q <= {1'b0, shreg_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     tx_q <= shreg_q[1];
                  end
               end else begin
                  timer_q <= timer_d;
               end
            end
            ST_STOP: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  timer_q <= timer_d;
               end
            end
         endcase
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;

   uart_rx #(
      .DIVISOR (DIVISOR)
   ) u_rx (
      .raw_clk        (raw_clk),
      .reset          (reset),
      .rx             (rx),
      .rx_ack         (rx_ack),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .rx_overrun     (rx_overrun),
      .rx_frame_error (rx_frame_error)
   );

endmodule

// File: tb/tb_uart_serial.sv
// Directed bench for uart_serial with DIVISOR=4: TX framing, back-to-back, reset abort,
// RX flags, glitch rejection, ack/completion race and loopback.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_uart_serial;

   logic       raw_clk = 1'b0;
   logic       reset   = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_busy;
   logic       tx;
   logic       rx;
   logic       rx_drv  = 1'b1;
   logic       loop_en = 1'b0;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_ack  = 1'b0;
   logic       rx_overrun;
   logic       rx_frame_error;

   int checks = 0;
   int errors = 0;

   assign rx = loop_en ? tx : rx_drv;

   always #5 raw_clk = ~raw_clk;

   uart_serial #(.DIVISOR(4)) dut (
      .raw_clk        (raw_clk),
      .reset          (reset),
      .tx_start       (tx_start),
      .tx_data        (tx_data),
      .tx_busy        (tx_busy),
      .tx             (tx),
      .rx             (rx),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .rx_ack         (rx_ack),
      .rx_overrun     (rx_overrun),
      .rx_frame_error (rx_frame_error)
   );

   // bits[9] is the first bit on the wire (start), bits[0] the stop bit.
   typedef struct {
      logic [7:0] data;
      logic [9:0] bits;
   } tx_vec_t;

   typedef struct {
      logic       ack_first;
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_rdy;
      logic       exp_ovr;
      logic       exp_ferr;
   } rx_vec_t;

   tx_vec_t tx_tab[4];
   rx_vec_t rx_tab[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge raw_clk);
      #1;
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
   endtask

   // Send one frame and check every cycle of tx/tx_busy against the expected wire pattern.
   task automatic tx_frame(input logic [7:0] d, input logic [9:0] bits);
      tx_start = 1'b1;
      tx_data  = d;
      step();
      tx_start = 1'b0;
      tx_data  = ~d;
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("tx_bit%0d_of_%02h", i / 4, d), {31'd0, tx}, {31'd0, bits[9 - i / 4]});
         chk($sformatf("tx_busy_c%0d_of_%02h", i, d), {31'd0, tx_busy}, 32'd1);
         step();
      end
      chk("tx_busy_end", {31'd0, tx_busy}, 32'd0);
      chk("tx_idle_high", {31'd0, tx}, 32'd1);
   endtask

   task automatic drive_rx(input logic [7:0] d, input logic stop);
      rx_drv = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (4) step();
      end
      rx_drv = stop;
      repeat (4) step();
      rx_drv = 1'b1;
      repeat (8) step();
   endtask

   initial begin
      logic       b_busy[82];
      logic       b_tx[82];
      logic [9:0] pat;
      int         nbusy;
      int         found;

      tx_tab[0] = '{8'hA5, 10'b0101001011};
      tx_tab[1] = '{8'h3C, 10'b0001111001};
      tx_tab[2] = '{8'h00, 10'b0000000001};
      tx_tab[3] = '{8'h81, 10'b0100000011};

      rx_tab[0] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
      rx_tab[1] = '{1'b0, 8'h22, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
      rx_tab[2] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
      rx_tab[3] = '{1'b1, 8'h55, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1};
      rx_tab[4] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

      // Reset state
      repeat (3) step();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("rst_flags", {29'd0, rx_ready, rx_overrun, rx_frame_error}, 32'd0);
      reset = 1'b0;
      repeat (3) step();

      // Single frames from the table
      for (int v = 0; v < 4; v++) begin
         tx_frame(tx_tab[v].data, tx_tab[v].bits);
         repeat (3) step();
      end

      // Back-to-back: tx_start held across two frames
      tx_start = 1'b1;
      tx_data  = 8'h00;
      step();
      tx_data  = 8'hFF;
      for (int j = 0; j < 82; j++) begin
         b_busy[j] = tx_busy;
         b_tx[j]   = tx;
         if (j == 41) tx_start = 1'b0;
         if (j != 81) step();
      end
      nbusy = 0;
      for (int j = 0; j < 82; j++) if (b_busy[j]) nbusy++;
      chk("b2b_busy_cycles", nbusy, 80);
      chk("b2b_gap_cycle", {31'd0, b_busy[40]}, 32'd0);
      chk("b2b_second_start", {31'd0, b_busy[41]}, 32'd1);
      chk("b2b_end_idle", {31'd0, b_busy[81]}, 32'd0);
      pat = '0;
      for (int b = 0; b < 10; b++) pat[9 - b] = b_tx[4 * b + 2];
      chk("b2b_frame0_bits", {22'd0, pat}, {22'd0, 10'b0000000001});
      pat = '0;
      for (int b = 0; b < 10; b++) pat[9 - b] = b_tx[41 + 4 * b + 2];
      chk("b2b_frame1_bits", {22'd0, pat}, {22'd0, 10'b0111111111});
      repeat (3) step();

      // Reset 15 cycles into a frame, then a clean frame
      tx_start = 1'b1;
      tx_data  = 8'hA5;
      step();
      tx_start = 1'b0;
      repeat (15) step();
      chk("pre_abort_busy", {31'd0, tx_busy}, 32'd1);
      reset = 1'b1;
      step();
      chk("abort_tx", {31'd0, tx}, 32'd1);
      chk("abort_busy", {31'd0, tx_busy}, 32'd0);
      reset = 1'b0;
      repeat (2) step();
      tx_frame(8'h81, 10'b0100000011);
      repeat (3) step();

      // Receive table: flags and held data after each frame
      for (int v = 0; v < 5; v++) begin
         if (rx_tab[v].ack_first) pulse_ack();
         drive_rx(rx_tab[v].data, rx_tab[v].stop);
         chk($sformatf("rx%0d_data", v), {24'd0, rx_data}, {24'd0, rx_tab[v].exp_data});
         chk($sformatf("rx%0d_ready", v), {31'd0, rx_ready}, {31'd0, rx_tab[v].exp_rdy});
         chk($sformatf("rx%0d_overrun", v), {31'd0, rx_overrun}, {31'd0, rx_tab[v].exp_ovr});
         chk($sformatf("rx%0d_ferr", v), {31'd0, rx_frame_error}, {31'd0, rx_tab[v].exp_ferr});
      end

      // One-cycle low glitch must not start a frame or raise flags
      pulse_ack();
      chk("ack_clears_ready", {31'd0, rx_ready}, 32'd0);
      rx_drv = 1'b0;
      step();
      rx_drv = 1'b1;
      repeat (12) step();
      chk("glitch_flags", {29'd0, rx_ready, rx_overrun, rx_frame_error}, 32'd0);
      chk("glitch_data", {24'd0, rx_data}, 32'h80);

      // Ack on the same edge as a completion: completion wins
      drive_rx(8'h99, 1'b1);
      drive_rx(8'h77, 1'b1);
      chk("race_pre_overrun", {31'd0, rx_overrun}, 32'd1);
      chk("race_pre_data", {24'd0, rx_data}, 32'h99);
      rx_ack = 1'b1;
      found  = 0;
      fork
         drive_rx(8'h5A, 1'b1);
         begin
            for (int k = 0; k < 80 && found == 0; k++) begin
               step();
               if (rx_data == 8'h5A) begin
                  found  = 1;
                  rx_ack = 1'b0;
               end
            end
            rx_ack = 1'b0;
         end
      join
      chk("race_completion_seen", found, 1);
      chk("race_ready", {31'd0, rx_ready}, 32'd1);
      chk("race_overrun", {31'd0, rx_overrun}, 32'd0);
      chk("race_data", {24'd0, rx_data}, 32'h5A);

      // Loopback: rx fed from tx
      pulse_ack();
      loop_en  = 1'b1;
      tx_start = 1'b1;
      tx_data  = 8'h3C;
      step();
      tx_start = 1'b0;
      found = 0;
      for (int k = 0; k < 100 && found == 0; k++) begin
         step();
         if (rx_ready) found = 1;
      end
      chk("loop_ready", found, 1);
      chk("loop_data", {24'd0, rx_data}, 32'h3C);
      chk("loop_ferr", {31'd0, rx_frame_error}, 32'd0);
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         if (!tx_busy) found = 1;
         else step();
      end
      chk("loop_tx_done", found, 1);
      pulse_ack();
      chk("loop_ack_clears", {31'd0, rx_ready}, 32'd0);
      loop_en = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
